// File: rtl/lutram_test_pkg.sv
// Shared encodings for the LUTRAM pattern tester.
// Holds FSM state encoding and pattern mode constants.
package lutram_test_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_WRITE = 3'd2,
        S_READ  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [1:0] MODE_ALTBIT = 2'd0;
    localparam logic [1:0] MODE_ADDR   = 2'd1;
    localparam logic [1:0] MODE_NADDR  = 2'd2;
    localparam logic [1:0] MODE_ONES   = 2'd3;

endpackage

// File: rtl/lutram_sp.sv
// Single-port distributed RAM: synchronous write, asynchronous read.
// Ports: clk_i, we_i, addr_i, d_i -> q_o. Contents are never reset.
module lutram_sp #(
    parameter int A_WIDTH = 6,
    parameter int D_WIDTH = 1
) (
    input  logic               clk_i,
    input  logic               we_i,
    input  logic [A_WIDTH-1:0] addr_i,
    input  logic [D_WIDTH-1:0] d_i,
    output logic [D_WIDTH-1:0] q_o
);

    (* ram_style = "distributed" *)
    logic [D_WIDTH-1:0] mem [2**A_WIDTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[addr_i] <= d_i;
        end
    end

    assign q_o = mem[addr_i];

endmodule

// File: rtl/lutram_pattern_tester.sv
// Clears, fills and reads back a LUTRAM with a selectable pattern.
// Ports: clk_i, rst_ni, start_i, mode_i, inject_i -> q_o, busy_o, done_o, pass_o, err_cnt_o, first_err_addr_o.
module lutram_pattern_tester
    import lutram_test_pkg::*;
#(
    parameter int          A_WIDTH         = 6,
    parameter int          D_WIDTH         = 1,
    parameter logic [31:0] DIV_COUNTER_END = 32'h00FF_FFFF
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic [1:0]         mode_i,
    input  logic               inject_i,
    output logic [D_WIDTH-1:0] q_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               pass_o,
    output logic [A_WIDTH:0]   err_cnt_o,
    output logic [A_WIDTH-1:0] first_err_addr_o
);

    function automatic logic [D_WIDTH-1:0] pattern(
        input logic [1:0]         m,
        input logic [A_WIDTH-1:0] a
    );
        logic [D_WIDTH-1:0] ext;
        ext = D_WIDTH'(a);
        unique case (m)
            MODE_ALTBIT: pattern = {D_WIDTH{a[0]}};
            MODE_ADDR:   pattern = ext;
            MODE_NADDR:  pattern = ~ext;
            default:     pattern = '1;
        endcase
    endfunction

    logic [31:0]        div_q;
    logic               tick;
    state_t             state_q, state_d;
    logic [A_WIDTH-1:0] addr_q, addr_d;
    logic [A_WIDTH:0]   err_q, err_d;
    logic [A_WIDTH-1:0] ferr_q, ferr_d;
    logic               fseen_q, fseen_d;
    logic [1:0]         mode_q, mode_d;
    logic               we;
    logic [D_WIDTH-1:0] wdata;
    logic               at_end;

    assign tick   = (div_q == DIV_COUNTER_END);
    assign at_end = (addr_q == '1);

    lutram_sp #(
        .A_WIDTH(A_WIDTH),
        .D_WIDTH(D_WIDTH)
    ) u_ram (
        .clk_i (clk_i),
        .we_i  (we & tick),
        .addr_i(addr_q),
        .d_i   (wdata),
        .q_o   (q_o)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        err_d   = err_q;
        ferr_d  = ferr_q;
        fseen_d = fseen_q;
        mode_d  = mode_q;
        we      = 1'b0;
        wdata   = pattern(mode_q, addr_q);
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    state_d = S_CLEAR;
                    mode_d  = mode_i;
                    addr_d  = '0;
                    err_d   = '0;
                    ferr_d  = '0;
                    fseen_d = 1'b0;
                end
            end
            S_CLEAR: begin
                we     = 1'b1;
                wdata  = '0;
                addr_d = addr_q + 1'b1;
                if (at_end) state_d = S_WRITE;
            end
            S_WRITE: begin
                we = 1'b1;
                // Fault injection flips one bit of the cell at address 0
                if (addr_q == '0) wdata[0] = wdata[0] ^ inject_i;
                addr_d = addr_q + 1'b1;
                if (at_end) state_d = S_READ;
            end
            S_READ: begin
                if (q_o != pattern(mode_q, addr_q)) begin
                    if (err_q != '1) err_d = err_q + 1'b1;
                    if (!fseen_q) begin
                        fseen_d = 1'b1;
                        ferr_d  = addr_q;
                    end
                end
                addr_d = addr_q + 1'b1;
                if (at_end) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_q   <= '0;
            state_q <= S_IDLE;
            addr_q  <= '0;
            err_q   <= '0;
            ferr_q  <= '0;
            fseen_q <= 1'b0;
            mode_q  <= MODE_ALTBIT;
        end else begin
            div_q <= tick ? 32'd0 : div_q + 32'd1;
            if (tick) begin
                state_q <= state_d;
                addr_q  <= addr_d;
                err_q   <= err_d;
                ferr_q  <= ferr_d;
                fseen_q <= fseen_d;
                mode_q  <= mode_d;
            end
        end
    end

    assign busy_o = (state_q == S_CLEAR) || (state_q == S_WRITE) ||
                    (state_q == S_READ);
    assign done_o = (state_q == S_DONE);
    assign pass_o = done_o && (err_q == '0);
    assign err_cnt_o        = err_q;
    assign first_err_addr_o = ferr_q;

endmodule
